mem_write_checker: RTL

Parametrised, self-checking memory-write monitor for processor testbenches. It sits beside the `top` DUT and snoops the data-memory write bus (`memwrite`, `adr`, `writedata`). It compares observed stores against a programmable table of expected address/data pairs, in either ordered or unordered mode. It reports pass, fail or timeout with a cause code, replacing hand-written single-compare `always` blocks in benches.

---
 rtl/mem_write_checker.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_write_checker.sv
// mem_write_checker: snoops a store bus and checks it against a programmable table
// of expected address/data pairs, in ordered or unordered mode, with timeout.
module mem_write_checker #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int IDXW    = 2,
  parameter int TIMEOUT = 4096,
  parameter int ORDERED = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IDXW-1:0]  cfg_idx,
  input  logic [WIDTH-1:0] cfg_adr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [IDXW:0]    cfg_count,
  input  logic             start,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [IDXW-1:0]  fail_idx,
  output logic [IDXW:0]    match_count,
  output logic [31:0]      cycle_count
);
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PASS, S_FAIL} state_t;
  state_t state;
  logic [WIDTH-1:0] exp_adr [DEPTH];
  logic [WIDTH-1:0] exp_data [DEPTH];
  logic [DEPTH-1:0] hit;
  logic [IDXW:0] cnt;
  logic [IDXW:0] mc_next;
  logic [31:0] cc_next;
  logic [IDXW-1:0] sel;
  logic sel_ok, hit_now, data_ok;
  // Unordered mode scans downward so the lowest-index candidate wins.
  always_comb begin
    sel_ok = 1'b0;
    sel = match_count[IDXW-1:0];
    if (ORDERED != 0) sel_ok = exp_adr[sel] == adr;
    else
      for (int i = DEPTH - 1; i >= 0; i--)
        if ((IDXW+1)'(i) < cnt && !hit[i] && exp_adr[i] == adr) begin
          sel_ok = 1'b1;
          sel = IDXW'(i);
        end
  end
  assign hit_now = memwrite && sel_ok;
  assign data_ok = exp_data[sel] == writedata;
  assign mc_next = match_count + 1'b1;
  assign cc_next = &cycle_count ? cycle_count : cycle_count + 32'd1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        exp_adr[i] <= '0;
        exp_data[i] <= '0;
      end
      hit <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
      fail_code <= 2'b00;
      fail_idx <= '0;
      match_count <= '0;
      cycle_count <= '0;
    end else if (state == S_ARMED) begin
      cycle_count <= cc_next;
      if (hit_now && !data_ok) begin
        state <= S_FAIL;
        busy <= 1'b0;
        fail <= 1'b1;
        done <= 1'b1;
        fail_code <= 2'b01;
        fail_idx <= sel;
      end else if (hit_now && mc_next == cnt) begin
        state <= S_PASS;
        busy <= 1'b0;
        pass <= 1'b1;
        done <= 1'b1;
        match_count <= mc_next;
      end else begin
        if (hit_now) begin
          hit[sel] <= 1'b1;
          match_count <= mc_next;
        end
        if (cc_next >= 32'(TIMEOUT)) begin
          state <= S_FAIL;
          busy <= 1'b0;
          fail <= 1'b1;
          done <= 1'b1;
          fail_code <= 2'b10;
        end
      end
    end else begin
      if (cfg_we) begin
        exp_adr[cfg_idx] <= cfg_adr;
        exp_data[cfg_idx] <= cfg_data;
      end
      if (start) begin
        cnt <= cfg_count;
        hit <= '0;
        match_count <= '0;
        cycle_count <= '0;
        fail_idx <= '0;
        fail_code <= cfg_count > (IDXW+1)'(DEPTH) ? 2'b11 : 2'b00;
        fail <= cfg_count > (IDXW+1)'(DEPTH);
        pass <= cfg_count == '0;
        done <= cfg_count > (IDXW+1)'(DEPTH) || cfg_count == '0;
        busy <= cfg_count <= (IDXW+1)'(DEPTH) && cfg_count != '0;
        state <= cfg_count > (IDXW+1)'(DEPTH) ? S_FAIL : cfg_count == '0 ? S_PASS : S_ARMED;
      end
    end
  end
endmodule
